// File: rtl/pulse_train_gen_16_pkg.sv
// Shared definitions for the pulse train generator: per-channel FSM
// encoding and default geometry/timing constants.
package pulse_train_gen_16_pkg;

    typedef enum logic [1:0] {
        CH_IDLE = 2'd0,
        CH_HIGH = 2'd1,
        CH_LOW  = 2'd2
    } chan_state_e;

    localparam int unsigned DEF_NCH     = 16;
    localparam int unsigned DEF_CW      = 16;
    localparam int unsigned DEF_PW_HIGH = 1;
    localparam int unsigned DEF_PW_LOW  = 1;
    localparam int unsigned PER_W       = 8;

endpackage

// File: rtl/pulse_chan_gen.sv
// One pulse channel: IDLE/HIGH/LOW FSM with a working pulse counter and a
// period counter that times the high and low phases.
module pulse_chan_gen
    import pulse_train_gen_16_pkg::*;
#(
    parameter int unsigned CW      = DEF_CW,
    parameter int unsigned PW_HIGH = DEF_PW_HIGH,
    parameter int unsigned PW_LOW  = DEF_PW_LOW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          launch,
    input  logic          kill,
    input  logic [CW-1:0] load_cnt,
    output logic          pulse,
    output logic          busy,
    output logic          busy_nxt
);

    localparam logic [PER_W-1:0] HI_RELOAD = PER_W'(PW_HIGH - 1);
    localparam logic [PER_W-1:0] LO_RELOAD = PER_W'(PW_LOW - 1);

    chan_state_e      state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PER_W-1:0] per_q, per_d;
    logic             pulse_q, pulse_d;
    logic             busy_q, busy_d;

    // The count is decremented on leaving HIGH, so it is always >= 1 there
    // and can never wrap.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        per_d   = per_q;
        if (kill) begin
            state_d = CH_IDLE;
            cnt_d   = '0;
            per_d   = '0;
        end else begin
            case (state_q)
                CH_IDLE: begin
                    if (launch && load_cnt != '0) begin
                        state_d = CH_HIGH;
                        cnt_d   = load_cnt;
                        per_d   = HI_RELOAD;
                    end
                end
                CH_HIGH: begin
                    if (per_q == '0) begin
                        state_d = CH_LOW;
                        cnt_d   = cnt_q - CW'(1);
                        per_d   = LO_RELOAD;
                    end else begin
                        per_d = per_q - PER_W'(1);
                    end
                end
                CH_LOW: begin
                    if (per_q == '0) begin
                        if (cnt_q != '0) begin
                            state_d = CH_HIGH;
                            per_d   = HI_RELOAD;
                        end else begin
                            state_d = CH_IDLE;
                        end
                    end else begin
                        per_d = per_q - PER_W'(1);
                    end
                end
                default: begin
                    state_d = CH_IDLE;
                    cnt_d   = '0;
                    per_d   = '0;
                end
            endcase
        end
        pulse_d = (state_d == CH_HIGH);
        busy_d  = (state_d != CH_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= CH_IDLE;
            cnt_q   <= '0;
            per_q   <= '0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            per_q   <= per_d;
            pulse_q <= pulse_d;
            busy_q  <= busy_d;
        end
    end

    assign pulse    = pulse_q;
    assign busy     = busy_q;
    assign busy_nxt = busy_d;

endmodule

// File: rtl/pulse_train_gen_16.sv
// Multi-channel pulse train generator: shadow count registers, start/abort
// qualification, per-channel generators and the run-completion strobe.
module pulse_train_gen_16
    import pulse_train_gen_16_pkg::*;
#(
    parameter int unsigned NCH     = DEF_NCH,
    parameter int unsigned CW      = DEF_CW,
    parameter int unsigned PW_HIGH = DEF_PW_HIGH,
    parameter int unsigned PW_LOW  = DEF_PW_LOW,
    localparam int unsigned CHW    = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cfg_we,
    input  logic [CHW-1:0]  cfg_ch,
    input  logic [CW-1:0]   cfg_cnt,
    input  logic            start,
    input  logic            abort,
    output logic [NCH-1:0]  pulse,
    output logic [NCH-1:0]  busy,
    output logic            done
);

    logic [CW-1:0]  shadow_q [NCH];
    logic [CW-1:0]  shadow_d [NCH];
    logic [NCH-1:0] busy_nxt;
    logic           start_acc;
    logic           run_q, run_d;
    logic           done_q, done_d;

    assign start_acc = start && !abort && (busy == '0);

    always_comb begin
        shadow_d = shadow_q;
        if (cfg_we && (32'(cfg_ch) < NCH)) begin
            shadow_d[cfg_ch] = cfg_cnt;
        end
    end

    // Completion is judged on the channels' next-state busy so that done
    // lands in the first cycle the registered busy vector reads all-zero.
    always_comb begin
        run_d  = (start_acc || run_q) && !abort && (busy_nxt != '0);
        done_d = (start_acc || run_q) && !abort && (busy_nxt == '0);
    end

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        pulse_chan_gen #(
            .CW      (CW),
            .PW_HIGH (PW_HIGH),
            .PW_LOW  (PW_LOW)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .launch   (start_acc),
            .kill     (abort),
            .load_cnt (shadow_q[g]),
            .pulse    (pulse[g]),
            .busy     (busy[g]),
            .busy_nxt (busy_nxt[g])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow_q <= '{default: '0};
            run_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            run_q    <= run_d;
            done_q   <= done_d;
        end
    end

    assign done = done_q;

endmodule

// File: tb/tb_pulse_train_gen_16.sv
// Self-checking bench: three generator configurations driven in lockstep and
// compared every cycle against a schedule-based reference model.
module tb_pulse_train_gen_16;

    localparam int NCH = 16;
    localparam int ND  = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [3:0]  cfg_ch;
    logic [15:0] cfg_cnt;
    logic        start;
    logic        abort;

    logic [15:0] pulse_a, pulse_b, pulse_c;
    logic [15:0] busy_a, busy_b, busy_c;
    logic        done_a, done_b, done_c;

    always #5 clk = ~clk;

    pulse_train_gen_16 u_dut_a (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_cnt(cfg_cnt),
        .start(start), .abort(abort), .pulse(pulse_a), .busy(busy_a), .done(done_a)
    );

    pulse_train_gen_16 #(.PW_HIGH(3), .PW_LOW(2)) u_dut_b (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_cnt(cfg_cnt),
        .start(start), .abort(abort), .pulse(pulse_b), .busy(busy_b), .done(done_b)
    );

    pulse_train_gen_16 #(.CW(10)) u_dut_c (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_cnt(cfg_cnt[9:0]),
        .start(start), .abort(abort), .pulse(pulse_c), .busy(busy_c), .done(done_c)
    );

    // Reference model: a run is described by its start cycle and a snapshot
    // of the counts; outputs at any cycle follow from arithmetic on those.
    int unsigned shadow [ND][NCH];
    int unsigned snap   [ND][NCH];
    int          s_n    [ND];
    bit          live   [ND];
    int unsigned maxlen [ND];
    int          cyc;
    int          n_cmp;
    int          n_bad;

    function automatic int unsigned ph(int d);
        return (d == 1) ? 3 : 1;
    endfunction

    function automatic int unsigned pl(int d);
        return (d == 1) ? 2 : 1;
    endfunction

    function automatic int unsigned cmask(int d);
        return (d == 2) ? 32'h3FF : 32'hFFFF;
    endfunction

    function automatic logic [15:0] exp_vec(int d, int t, bit want_pulse);
        logic [15:0] v = '0;
        int unsigned p = ph(d) + pl(d);
        if (live[d] && t > s_n[d]) begin
            int unsigned k = int'(t - s_n[d] - 1);
            for (int i = 0; i < NCH; i++) begin
                if (k < snap[d][i] * p) begin
                    v[i] = want_pulse ? ((k % p) < ph(d)) : 1'b1;
                end
            end
        end
        return v;
    endfunction

    function automatic logic exp_done(int d, int t);
        return live[d] && (t == s_n[d] + 1 + int'(maxlen[d]));
    endfunction

    function automatic logic [15:0] act_pulse(int d);
        case (d)
            0:       return pulse_a;
            1:       return pulse_b;
            default: return pulse_c;
        endcase
    endfunction

    function automatic logic [15:0] act_busy(int d);
        case (d)
            0:       return busy_a;
            1:       return busy_b;
            default: return busy_c;
        endcase
    endfunction

    function automatic logic act_done(int d);
        case (d)
            0:       return done_a;
            1:       return done_b;
            default: return done_c;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic compare_all();
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("pulse[dut%0d]", d), 32'(act_pulse(d)), 32'(exp_vec(d, cyc, 1'b1)));
            chk($sformatf("busy[dut%0d]", d),  32'(act_busy(d)),  32'(exp_vec(d, cyc, 1'b0)));
            chk($sformatf("done[dut%0d]", d),  32'(act_done(d)),  32'(exp_done(d, cyc)));
        end
    endtask

    task automatic model_edge();
        for (int d = 0; d < ND; d++) begin
            bit acc = start && !abort && (exp_vec(d, cyc, 1'b0) == '0);
            if (abort) begin
                live[d] = 1'b0;
            end else if (acc) begin
                live[d]   = 1'b1;
                s_n[d]    = cyc;
                maxlen[d] = 0;
                for (int i = 0; i < NCH; i++) begin
                    snap[d][i] = shadow[d][i];
                    if (shadow[d][i] * (ph(d) + pl(d)) > maxlen[d])
                        maxlen[d] = shadow[d][i] * (ph(d) + pl(d));
                end
            end
            if (cfg_we) shadow[d][cfg_ch] = 32'(cfg_cnt) & cmask(d);
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        cyc++;
        #1;
        compare_all();
    endtask

    task automatic wr(input int ch, input int unsigned cnt);
        cfg_we  = 1'b1;
        cfg_ch  = 4'(ch);
        cfg_cnt = 16'(cnt);
        step();
        cfg_we  = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    function automatic bit any_active();
        for (int d = 0; d < ND; d++)
            if (live[d] && cyc <= s_n[d] + 1 + int'(maxlen[d])) return 1'b1;
        return 1'b0;
    endfunction

    task automatic wait_quiet();
        int budget = 8000;
        while (any_active() && budget > 0) begin
            step();
            budget--;
        end
        if (budget == 0) chk("wait_quiet_timeout", 32'd1, 32'd0);
        step();
    endtask

    task automatic do_reset();
        cfg_we = 1'b0;
        start  = 1'b0;
        abort  = 1'b0;
        #2;
        rst = 1'b0;
        for (int d = 0; d < ND; d++) begin
            live[d] = 1'b0;
            for (int i = 0; i < NCH; i++) shadow[d][i] = 0;
        end
        #1;
        compare_all();
        @(posedge clk);
        cyc++;
        #1;
        compare_all();
        rst = 1'b1;
    endtask

    initial begin
        int edges;
        logic prev;
        n_cmp   = 0;
        n_bad   = 0;
        cyc     = 0;
        rst     = 1'b0;
        cfg_we  = 1'b0;
        cfg_ch  = '0;
        cfg_cnt = '0;
        start   = 1'b0;
        abort   = 1'b0;
        for (int d = 0; d < ND; d++) begin
            live[d] = 1'b0;
            s_n[d]  = 0;
            maxlen[d] = 0;
            for (int i = 0; i < NCH; i++) begin
                shadow[d][i] = 0;
                snap[d][i]   = 0;
            end
        end

        repeat (2) begin
            @(posedge clk);
            cyc++;
            #1;
            compare_all();
        end
        rst = 1'b1;
        step();

        // Basic run, then all-zero run
        wr(0, 3);
        wr(5, 1);
        go();
        wait_quiet();
        wr(0, 0);
        wr(5, 0);
        go();
        wait_quiet();

        // Abort mid-run, then rerun the same counts
        wr(2, 10);
        go();
        repeat (3) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        repeat (3) step();
        go();
        wait_quiet();

        // Same-cycle write and start: old value wins
        wr(2, 0);
        wr(1, 2);
        cfg_we  = 1'b1;
        cfg_ch  = 4'd1;
        cfg_cnt = 16'd7;
        start   = 1'b1;
        step();
        cfg_we  = 1'b0;
        start   = 1'b0;
        wait_quiet();
        go();
        repeat (4) step();
        go();
        wait_quiet();

        // Start together with abort
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        repeat (3) step();

        // Maximum count for the 10-bit instance
        wr(1, 0);
        wr(3, 16'h03FF);
        go();
        edges = 0;
        prev  = 1'b0;
        begin
            int budget = 8000;
            while (any_active() && budget > 0) begin
                if (pulse_c[3] && !prev) edges++;
                prev = pulse_c[3];
                step();
                budget--;
            end
            if (budget == 0) chk("max_run_timeout", 32'd1, 32'd0);
        end
        chk("max_count_edges", 32'(edges), 32'd1023);
        step();

        // Reset in the middle of a count-5 run
        wr(3, 0);
        wr(4, 5);
        go();
        repeat (2) step();
        do_reset();
        go();
        wait_quiet();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            cfg_we  = ($urandom % 4) == 0;
            cfg_ch  = 4'($urandom % 16);
            cfg_cnt = (($urandom % 8) == 0) ? 16'($urandom % 40) : 16'($urandom % 6);
            start   = ($urandom % 6) == 0;
            abort   = ($urandom % 60) == 0;
            if (($urandom % 700) == 0) begin
                do_reset();
            end else begin
                step();
            end
        end
        cfg_we = 1'b0;
        start  = 1'b0;
        abort  = 1'b0;
        wait_quiet();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
